// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial ripple subtractor.
// Holds the controller state encoding used by the top-level FSM.
// The value 2'd3 is unused and recovers to S_IDLE.
package serial_ripple_subtractor_pkg;

  // Controller states; 2'd3 is deliberately left unassigned.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-count width for a given operand width. The extra bit keeps the
  // terminal count representable without ambiguity.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_fs.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational, zero latency.
// No flow control; the enclosing FSM decides when the outputs are used.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference is the parity of the three inputs.
  assign d    = a ^ b ^ bin;

  // Borrow when b exceeds a outright, or when they match and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: D = A - B (mod 2^WIDTH), one bit per clock, LSB first.
// Latency: start accepted at edge k -> D/BOUT loaded and done=1 after edge k+WIDTH.
// start is only honoured in IDLE; requests while busy are dropped, not queued.
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);

  localparam int             CW       = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             bout_bit;

  // The single arithmetic cell always looks at the current LSBs and the
  // borrow carried from the previous bit.
  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Controller, operand/result shifters and registered status outputs.
  // D and BOUT are only written on the final bit so no partial results leak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      BOUT   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          borrow <= bout_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            D     <= {d_bit, res_sh[WIDTH-1:1]};
            BOUT  <= bout_bit;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor (WIDTH=4).
// Driver predicts acceptance and results from arithmetic; monitor checks every cycle.
// Inputs change 2 time units after a rising edge, outputs sampled 6 units after it.
module tb_serial_ripple_subtractor;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         BOUT;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .BOUT  (BOUT)
  );

  always #5 clk = ~clk;

  // Edge counter: value is the number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int d;
    int bout;
    int edge_n;
  } exp_t;

  exp_t sbq[$];

  int  checks    = 0;
  int  failures  = 0;
  int  next_ok   = 0;
  int  ka        = -100;
  int  last_d    = 0;
  int  last_bout = 0;
  int  n_accept  = 0;
  bit  mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive start/A/B for the next edge and predict whether it is accepted.
  task automatic drive(input bit s, input int a, input int b);
    int e;
    int at;
    int bt;
    exp_t x;
    at    = a & MASK;
    bt    = b & MASK;
    start = s;
    A     = at[W-1:0];
    B     = bt[W-1:0];
    e     = cyc + 1;
    if (s && !rst && e >= next_ok) begin
      x.d      = (at - bt) & MASK;
      x.bout   = (at < bt) ? 1 : 0;
      x.edge_n = e + W;
      sbq.push_back(x);
      ka       = e;
      next_ok  = e + W + 2;
      n_accept++;
    end
  endtask

  // One request pulse, then wait out the full operation.
  task automatic op(input int a, input int b);
    drive(1'b1, a, b);
    step();
    drive(1'b0, $urandom, $urandom);
    repeat (W + 1) step();
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst   = 1'b1;
    sbq.delete();
    next_ok   = 0;
    ka        = -100;
    last_d    = 0;
    last_bout = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_D",    D,    0);
    chk("rst_BOUT", BOUT, 0);
    step();
    rst = 1'b0;
  endtask

  // Monitor: done timing, busy window, result values and hold behaviour.
  initial begin
    forever begin
      @(posedge clk);
      #6;
      if (!rst && mon_en) begin
        bit exp_done;
        exp_done = (sbq.size() > 0) && (sbq[0].edge_n == cyc);
        chk("done", done, exp_done);
        chk("busy", busy, (cyc >= ka && cyc <= ka + W) ? 1 : 0);
        if (exp_done) begin
          exp_t x;
          x = sbq.pop_front();
          chk("D",    D,    x.d);
          chk("BOUT", BOUT, x.bout);
          last_d    = x.d;
          last_bout = x.bout;
        end else begin
          chk("D_hold",    D,    last_d);
          chk("BOUT_hold", BOUT, last_bout);
          if (sbq.size() > 0 && sbq[0].edge_n < cyc) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int guard;
    int acc0;

    #1;
    rst = 1'b1;
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_D",    D,    0);
    chk("init_BOUT", BOUT, 0);
    repeat (2) step();
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // Directed cases.
    op(5, 3);
    op(3, 5);
    op(0, 1);
    op(15, 15);
    op(15, 0);

    // Exhaustive operand pairs.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(a, b);

    // Requests during RUN and DONE are dropped.
    drive(1'b1, 9, 4);
    step();
    drive(1'b0, 0, 0);
    step();
    drive(1'b1, 1, 2);
    step();
    drive(1'b0, 0, 0);
    step();
    step();
    drive(1'b1, 1, 2);
    step();
    drive(1'b0, 0, 0);
    repeat (2) step();

    // Reset two RUN edges into an operation, then a fresh operation.
    drive(1'b1, 6, 7);
    step();
    drive(1'b0, 0, 0);
    repeat (2) step();
    do_reset();
    repeat (3) step();
    op(7, 6);

    // start held high: accepts must land every W+2 edges.
    acc0 = n_accept;
    for (int i = 0; i < 6 * (W + 2); i++) begin
      drive(1'b1, $urandom, $urandom);
      step();
    end
    drive(1'b0, 0, 0);
    chk("held_accepts", n_accept - acc0, 6);

    // Random request pattern.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0), $urandom, $urandom);
      step();
    end
    drive(1'b0, 0, 0);

    // Drain outstanding expectations with a bounded wait.
    guard = 0;
    while (sbq.size() > 0 && guard < 50) begin
      step();
      guard++;
    end
    chk("drain", sbq.size(), 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
